// File: rtl/beat_pkg.sv
// Shared types for the beat scroller: note encoding and sequencer states.
// Used by beat_scroller and note_lane.
package beat_pkg;

    typedef logic [1:0] note_t;

    localparam note_t NOTE_EMPTY = 2'b00;
    localparam note_t NOTE_DON   = 2'b01;
    localparam note_t NOTE_KA    = 2'b10;
    localparam note_t NOTE_END   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/note_lane.sv
// On-screen note lane: LANE_LEN x 2-bit shift register, slot 0 is the hit
// position. Shift beats head clear, since the head leaves the lane anyway.
module note_lane
    import beat_pkg::*;
#(
    parameter int LANE_LEN = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                shift,
    input  logic                clear_head,
    input  logic                clear_all,
    input  note_t               load,
    output note_t               head,
    output logic [LANE_LEN-1:0] lane_don,
    output logic [LANE_LEN-1:0] lane_ka
);

    logic [LANE_LEN-1:0] don_q;
    logic [LANE_LEN-1:0] ka_q;

    // Lane storage: clear, shift toward slot 0, or drop a hit note.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            don_q <= '0;
            ka_q  <= '0;
        end else if (clear_all) begin
            don_q <= '0;
            ka_q  <= '0;
        end else if (shift) begin
            don_q <= {load == NOTE_DON, don_q[LANE_LEN-1:1]};
            ka_q  <= {load == NOTE_KA, ka_q[LANE_LEN-1:1]};
        end else if (clear_head) begin
            don_q[0] <= 1'b0;
            ka_q[0]  <= 1'b0;
        end
    end

    assign head     = {ka_q[0], don_q[0]};
    assign lane_don = don_q;
    assign lane_ka  = ka_q;

endmodule

// File: rtl/beat_scroller.sv
// Note-lane sequencer: scrolls beatmap notes on tick, judges drum hits.
// BEAT_SCROLLER_COMBO_EN adds a combo counter and a combo score bonus.
module beat_scroller
    import beat_pkg::*;
#(
    parameter int LANE_LEN   = 16,
    parameter int ADDR_W     = 12,
    parameter int SCORE_W    = 16,
    parameter int HIT_POINTS = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick,
    input  logic                start,
    output logic [ADDR_W-1:0]   note_addr,
    input  logic [1:0]          note_data,
    input  logic                hit_don,
    input  logic                hit_ka,
    output logic [LANE_LEN-1:0] lane_don,
    output logic [LANE_LEN-1:0] lane_ka,
    output logic [SCORE_W-1:0]  score,
`ifdef BEAT_SCROLLER_COMBO_EN
    output logic [SCORE_W-1:0]  combo,
`endif
    output logic                judge_good,
    output logic                judge_miss,
    output logic                playing,
    output logic                song_done
);

    localparam int CW = $clog2(LANE_LEN + 1);
    localparam int SW = SCORE_W + 2;

    state_t            state;
    logic [CW-1:0]     drain_cnt;
    note_t             head;
    note_t             want;
    note_t             load;
    logic              active;
    logic              do_tick;
    logic              press;
    logic              both;
    logic              good;
    logic              miss;
    logic              begin_song;
    logic [SW-1:0]     sum;
    logic [SCORE_W-1:0] score_nxt;

    assign active     = (state == PLAY) || (state == DRAIN);
    assign do_tick    = active && tick;
    assign press      = active && (hit_don ^ hit_ka);
    assign both       = active && hit_don && hit_ka;
    assign want       = hit_don ? NOTE_DON : NOTE_KA;
    assign good       = press && (head == want);
    // A wrong press and a shift-out in the same cycle merge into one miss.
    assign miss       = (press && !good) || both ||
                        (do_tick && (head != NOTE_EMPTY) && !good);
    assign begin_song = start && ((state == IDLE) || (state == DONE));
    assign load       = ((state == PLAY) && (note_data != NOTE_END)) ?
                        note_data : NOTE_EMPTY;

`ifdef BEAT_SCROLLER_COMBO_EN
    assign sum = SW'(score) + SW'(HIT_POINTS) + SW'(combo >> 3);
`else
    assign sum = SW'(score) + SW'(HIT_POINTS);
`endif
    assign score_nxt = (|sum[SW-1:SCORE_W]) ? '1 : sum[SCORE_W-1:0];

    note_lane #(
        .LANE_LEN   (LANE_LEN)
    ) u_lane (
        .clock      (clock),
        .reset      (reset),
        .shift      (do_tick),
        .clear_head (good),
        .clear_all  (begin_song),
        .load       (load),
        .head       (head),
        .lane_don   (lane_don),
        .lane_ka    (lane_ka)
    );

    // Song FSM with registered address, score, judges and status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            note_addr  <= '0;
            score      <= '0;
            drain_cnt  <= '0;
            judge_good <= 1'b0;
            judge_miss <= 1'b0;
            playing    <= 1'b0;
            song_done  <= 1'b0;
        end else begin
            judge_good <= good;
            judge_miss <= miss;
            if (good) begin
                score <= score_nxt;
            end
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= PLAY;
                        note_addr <= '0;
                        score     <= '0;
                        drain_cnt <= '0;
                        playing   <= 1'b1;
                        song_done <= 1'b0;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        if (note_data == NOTE_END || (&note_addr)) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            note_addr <= note_addr + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (tick) begin
                        if (drain_cnt == CW'(LANE_LEN - 1)) begin
                            state     <= DONE;
                            playing   <= 1'b0;
                            song_done <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

`ifdef BEAT_SCROLLER_COMBO_EN
    // Combo streak: grows on good hits, broken by any miss or a new song.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            combo <= '0;
        end else if (begin_song || miss) begin
            combo <= '0;
        end else if (good && !(&combo)) begin
            combo <= combo + SCORE_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_beat_scroller.sv
// Table-driven bench for beat_scroller with a small beatmap ROM model.
// Expected records are queued at drive time and popped after each edge.
module tb_beat_scroller;

    localparam int LL = 8;
    localparam int AW = 4;
    localparam int SW = 6;
    localparam int HP = 10;

    localparam logic [3:0] I = 4'b0000;
    localparam logic [3:0] S = 4'b1000;
    localparam logic [3:0] T = 4'b0100;
    localparam logic [3:0] D = 4'b0010;
    localparam logic [3:0] K = 4'b0001;
    localparam logic [LL-1:0] FULL = '1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          start = 1'b0;
    logic          hit_don = 1'b0;
    logic          hit_ka = 1'b0;
    logic [AW-1:0] note_addr;
    logic [1:0]    note_data;
    logic [LL-1:0] lane_don;
    logic [LL-1:0] lane_ka;
    logic [SW-1:0] score;
`ifdef BEAT_SCROLLER_COMBO_EN
    logic [SW-1:0] combo;
`endif
    logic          judge_good;
    logic          judge_miss;
    logic          playing;
    logic          song_done;

    logic [1:0]    rom [16];

    typedef struct {
        logic [3:0]    in;
        logic          jg;
        logic          jm;
        logic [SW-1:0] sc;
        logic [AW-1:0] ad;
        logic          pl;
        logic          dn;
        logic [LL-1:0] ld;
        logic [LL-1:0] lk;
        logic [LL-1:0] msk;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    beat_scroller #(
        .LANE_LEN   (LL),
        .ADDR_W     (AW),
        .SCORE_W    (SW),
        .HIT_POINTS (HP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .start      (start),
        .note_addr  (note_addr),
        .note_data  (note_data),
        .hit_don    (hit_don),
        .hit_ka     (hit_ka),
        .lane_don   (lane_don),
        .lane_ka    (lane_ka),
        .score      (score),
`ifdef BEAT_SCROLLER_COMBO_EN
        .combo      (combo),
`endif
        .judge_good (judge_good),
        .judge_miss (judge_miss),
        .playing    (playing),
        .song_done  (song_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) note_data <= rom[note_addr];

    function automatic vec_t mk(input logic [3:0] in, input logic jg,
                                input logic jm, input int sc, input int ad,
                                input logic pl, input logic dn,
                                input logic [LL-1:0] ld,
                                input logic [LL-1:0] lk,
                                input logic [LL-1:0] msk);
        vec_t v;
        v.in = in;
        v.jg = jg;
        v.jm = jm;
        v.sc = SW'(sc);
        v.ad = AW'(ad);
        v.pl = pl;
        v.dn = dn;
        v.ld = ld;
        v.lk = lk;
        v.msk = msk;
        return v;
    endfunction

    function automatic void r(input logic [3:0] in, input logic jg,
                              input logic jm, input int sc, input int ad,
                              input logic pl, input logic dn,
                              input logic [LL-1:0] ld,
                              input logic [LL-1:0] lk);
        tbl.push_back(mk(in, jg, jm, sc, ad, pl, dn, ld, lk, FULL));
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        {start, tick, hit_don, hit_ka} = v.in;
        exp_q.push_back(v);
        @(posedge clock);
        #1;
        {start, tick, hit_don, hit_ka} = 4'b0000;
        e = exp_q.pop_front();
        chk($sformatf("r%0d judge_good", idx), 32'(judge_good), 32'(e.jg));
        chk($sformatf("r%0d judge_miss", idx), 32'(judge_miss), 32'(e.jm));
        chk($sformatf("r%0d score", idx), 32'(score), 32'(e.sc));
        chk($sformatf("r%0d note_addr", idx), 32'(note_addr), 32'(e.ad));
        chk($sformatf("r%0d playing", idx), 32'(playing), 32'(e.pl));
        chk($sformatf("r%0d song_done", idx), 32'(song_done), 32'(e.dn));
        chk($sformatf("r%0d lane_don", idx), 32'(lane_don & e.msk),
            32'(e.ld & e.msk));
        chk($sformatf("r%0d lane_ka", idx), 32'(lane_ka & e.msk),
            32'(e.lk & e.msk));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " note_addr"}, 32'(note_addr), 0);
        chk({tag, " score"}, 32'(score), 0);
        chk({tag, " judge_good"}, 32'(judge_good), 0);
        chk({tag, " judge_miss"}, 32'(judge_miss), 0);
        chk({tag, " playing"}, 32'(playing), 0);
        chk({tag, " song_done"}, 32'(song_done), 0);
        chk({tag, " lane_don"}, 32'(lane_don), 0);
        chk({tag, " lane_ka"}, 32'(lane_ka), 0);
    endtask

    initial begin
        int sc;
        int n;
        vec_t v;
        for (int i = 0; i < 16; i++) rom[i] = 2'b00;
        rom[0] = 2'b01;
        rom[1] = 2'b00;
        rom[2] = 2'b10;
        rom[3] = 2'b11;

        // scroll, good hit, wrong press, passive miss, song end, restart
        r(S, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
        r(I, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
        r(T, 0, 0, 0, 1, 1, 0, 8'h80, 8'h00);
        r(I, 0, 0, 0, 1, 1, 0, 8'h80, 8'h00);
        r(T, 0, 0, 0, 2, 1, 0, 8'h40, 8'h00);
        r(I, 0, 0, 0, 2, 1, 0, 8'h40, 8'h00);
        r(T, 0, 0, 0, 3, 1, 0, 8'h20, 8'h80);
        r(I, 0, 0, 0, 3, 1, 0, 8'h20, 8'h80);
        r(T, 0, 0, 0, 3, 1, 0, 8'h10, 8'h40);
        r(I, 0, 0, 0, 3, 1, 0, 8'h10, 8'h40);
        r(T, 0, 0, 0, 3, 1, 0, 8'h08, 8'h20);
        r(I, 0, 0, 0, 3, 1, 0, 8'h08, 8'h20);
        r(T, 0, 0, 0, 3, 1, 0, 8'h04, 8'h10);
        r(I, 0, 0, 0, 3, 1, 0, 8'h04, 8'h10);
        r(T, 0, 0, 0, 3, 1, 0, 8'h02, 8'h08);
        r(I, 0, 0, 0, 3, 1, 0, 8'h02, 8'h08);
        r(T, 0, 0, 0, 3, 1, 0, 8'h01, 8'h04);
        r(D, 1, 0, 10, 3, 1, 0, 8'h00, 8'h04);
        r(I, 0, 0, 10, 3, 1, 0, 8'h00, 8'h04);
        r(T, 0, 0, 10, 3, 1, 0, 8'h00, 8'h02);
        r(I, 0, 0, 10, 3, 1, 0, 8'h00, 8'h02);
        r(T, 0, 0, 10, 3, 1, 0, 8'h00, 8'h01);
        r(D, 0, 1, 10, 3, 1, 0, 8'h00, 8'h01);
        r(I, 0, 0, 10, 3, 1, 0, 8'h00, 8'h01);
        r(T, 0, 1, 10, 3, 1, 0, 8'h00, 8'h00);
        r(I, 0, 0, 10, 3, 1, 0, 8'h00, 8'h00);
        r(T, 0, 0, 10, 3, 0, 1, 8'h00, 8'h00);
        r(I, 0, 0, 10, 3, 0, 1, 8'h00, 8'h00);
        r(T, 0, 0, 10, 3, 0, 1, 8'h00, 8'h00);
        r(D, 0, 0, 10, 3, 0, 1, 8'h00, 8'h00);
        r(S, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
        // start ignored while playing, tick+hit, double press, merged miss
        r(I, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
        r(T, 0, 0, 0, 1, 1, 0, 8'h80, 8'h00);
        r(S, 0, 0, 0, 1, 1, 0, 8'h80, 8'h00);
        r(T, 0, 0, 0, 2, 1, 0, 8'h40, 8'h00);
        r(I, 0, 0, 0, 2, 1, 0, 8'h40, 8'h00);
        r(T, 0, 0, 0, 3, 1, 0, 8'h20, 8'h80);
        r(I, 0, 0, 0, 3, 1, 0, 8'h20, 8'h80);
        r(T, 0, 0, 0, 3, 1, 0, 8'h10, 8'h40);
        r(I, 0, 0, 0, 3, 1, 0, 8'h10, 8'h40);
        r(T, 0, 0, 0, 3, 1, 0, 8'h08, 8'h20);
        r(S, 0, 0, 0, 3, 1, 0, 8'h08, 8'h20);
        r(T, 0, 0, 0, 3, 1, 0, 8'h04, 8'h10);
        r(I, 0, 0, 0, 3, 1, 0, 8'h04, 8'h10);
        r(T, 0, 0, 0, 3, 1, 0, 8'h02, 8'h08);
        r(I, 0, 0, 0, 3, 1, 0, 8'h02, 8'h08);
        r(T, 0, 0, 0, 3, 1, 0, 8'h01, 8'h04);
        r(I, 0, 0, 0, 3, 1, 0, 8'h01, 8'h04);
        r(T | D, 1, 0, 10, 3, 1, 0, 8'h00, 8'h02);
        r(I, 0, 0, 10, 3, 1, 0, 8'h00, 8'h02);
        r(T, 0, 0, 10, 3, 1, 0, 8'h00, 8'h01);
        r(D | K, 0, 1, 10, 3, 1, 0, 8'h00, 8'h01);
        r(I, 0, 0, 10, 3, 1, 0, 8'h00, 8'h01);
        r(T | D, 0, 1, 10, 3, 1, 0, 8'h00, 8'h00);
        r(I, 0, 0, 10, 3, 1, 0, 8'h00, 8'h00);
        r(T, 0, 0, 10, 3, 0, 1, 8'h00, 8'h00);

        #12;
        chk_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // all-don beatmap: address stops at all-ones, score saturates
        for (int i = 0; i < 16; i++) rom[i] = 2'b01;
        n = 100;
        apply(mk(S, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, FULL), n++);
        apply(mk(I, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, FULL), n++);
        sc = 0;
        for (int k = 1; k <= 16; k++) begin
            v = mk(T, 0, 0, sc, (k < 15) ? k : 15, 1, 0,
                   (k >= 8) ? 8'h01 : 8'h00, 8'h00, 8'h01);
            apply(v, n++);
            if (k >= 8) begin
                sc = (sc + HP > 63) ? 63 : sc + HP;
                v = mk(D, 1, 0, sc, (k < 15) ? k : 15, 1, 0,
                       8'h00, 8'h00, 8'h01);
            end else begin
                v = mk(D, 0, 1, sc, k, 1, 0, 8'h00, 8'h00, 8'h01);
            end
            apply(v, n++);
        end
        chk("saturated score", 32'(score), 63);

        // asynchronous reset mid-song while a good pulse is showing
        #3;
        reset = 1'b1;
        #1;
        chk_zero("async reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        apply(mk(T, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, FULL), n++);
        apply(mk(D, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, FULL), n++);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
